vec_popcount_pipe: RTL and testbench
====================================

VEC_POPCOUNT_PIPE -- requirements
Module: vec_popcount_pipe

Interface
REQ-001 SHALL have parameter VEC_WIDTH, default 64: input vector width, legal range 1..1024.
REQ-002 SHALL have parameter TAG_WIDTH, default 8: sideband tag carried alongside each vector, legal range 1..32.
REQ-003 SHALL have derived parameter POPCNT_WIDTH, default $clog2(VEC_WIDTH+1): count width.
REQ-004 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid, input, 1: in_vec/in_tag valid.
REQ-007 SHALL have port in_ready, output, 1: pipeline accepts input this cycle.
REQ-008 SHALL have port in_vec, input, VEC_WIDTH: vector to count.
REQ-009 SHALL have port in_tag, input, TAG_WIDTH: opaque tag, returned unchanged.
REQ-010 SHALL have port thresh, input, POPCNT_WIDTH: runtime compare threshold, sampled with each accepted input.
REQ-011 SHALL have port out_valid, output, 1: out_cnt/out_tag/out_ge valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-013 SHALL have port out_cnt, output, POPCNT_WIDTH: number of 1 bits in the accepted in_vec.
REQ-014 SHALL have port out_tag, output, TAG_WIDTH: in_tag of the same transaction.
REQ-015 SHALL have port out_ge, output, 1: out_cnt >= sampled thresh.

Function
REQ-016 SHALL split in_vec into NCHUNK = ceil(VEC_WIDTH/6) chunks of 6 bits, LSB first; the top chunk is zero-padded.
REQ-017 SHALL count each chunk with one 6-input LUT popcount (3-bit result), registered as stage 0.
REQ-018 SHALL sum chunk counts with a binary adder tree of DEPTH = ceil(log2(NCHUNK)) levels (0 when NCHUNK=1), each level registered.
REQ-019 SHALL widen each tree level by 1 bit, truncated to POPCNT_WIDTH; the sum SHALL never overflow.
REQ-020 SHALL compare against thresh in the final tree stage, with no extra cycle.
REQ-021 SHALL have LATENCY = 1 + DEPTH cycles from accept to out_valid when unstalled (VEC_WIDTH=64: NCHUNK=11, DEPTH=4, LATENCY=5).
REQ-022 SHALL accept a transaction on a cycle where in_valid && in_ready.
REQ-023 SHALL retire a transaction on a cycle where out_valid && out_ready.
REQ-024 SHALL advance all stages together when adv = out_ready || !out_valid; in_ready = adv (combinational).
REQ-025 SHALL move a bubble (valid=0) through a stage when in_valid=0 during adv.
REQ-026 SHALL hold every stage's data, tag, thresh and valid when adv=0; out_* SHALL be stable while out_valid && !out_ready.
REQ-027 SHALL sustain throughput of 1 transaction/cycle with out_ready held high.
REQ-028 SHALL deliver results in acceptance order; no reordering or drop.
REQ-029 SHALL treat a simultaneous accept and retire in one cycle as legal, with both taking effect.
REQ-030 SHALL propagate tag and thresh in per-stage shadow registers gated by the same adv.

Reset
REQ-031 SHALL clear all stage valid bits, out_valid, out_cnt, out_tag and out_ge to 0 asynchronously when rst_n=0.
REQ-032 SHALL discard in-flight transactions on reset mid-operation, with none emitted after release.
REQ-033 SHALL hold in_ready=0 during reset, and =1 on the first cycle after release.
REQ-034 SHALL leave data registers other than outputs and valid bits free of reset.

Structure
REQ-035 SHALL place CHUNK_W=6 and the function computing NCHUNK/DEPTH in shared package popcnt_pkg.
REQ-036 SHALL implement the chunk counter as sub-module lut6_popcount (6-bit in, 3-bit out, combinational), instantiated NCHUNK times.
REQ-037 SHALL generate the adder tree with generate loops, with no per-width hand coding.

Verification
REQ-038 SHALL cover VEC_WIDTH=64: in_vec=all-ones, thresh=64, out_ready=1 -> out_cnt=64, out_ge=1, exactly 5 cycles after accept.
REQ-039 SHALL cover back-to-back 0x0, 0x1, 0x8000_0000_0000_0001, 0xFFFF_FFFF with tags 1..4, thresh=2 -> cnt 0,1,2,32; ge 0,0,1,1; tags 1..4 on consecutive cycles.
REQ-040 SHALL cover out_ready=0 for 10 cycles with 8 accepted -> in_ready falls once the pipe is full, no output change while stalled, all 8 delivered in order after release.
REQ-041 SHALL cover VEC_WIDTH=7 (zero-padding) and VEC_WIDTH=6 (DEPTH=0): in_vec all-ones -> cnt 7 at latency 2, and cnt 6 at latency 1.
REQ-042 SHALL cover rst_n low for 1 cycle with 3 in flight -> out_valid=0, none of the 3 emitted, next accepted vector counted correctly.
REQ-043 SHALL cover 10k random vectors/tags with random out_ready -> scoreboard matches $countones and tag order with zero mismatches.

Source files
------------

// File: rtl/popcnt_pkg.sv
// ---------------------------------------------------------------------------
// popcnt_pkg
// Shared constants and elaboration-time helpers for the pipelined popcount.
// The input vector is cut into CHUNK_W-bit chunks, and each chunk is counted
// by one 6-input LUT. The per-chunk counts are then reduced by a registered
// binary adder tree.
//   calc_nchunk : number of chunks for a given vector width
//   calc_depth  : number of adder-tree levels for a given chunk count
//   nodes_at    : number of tree nodes at a given level
//   lvl_width   : bit width of the nodes at a given level
// ---------------------------------------------------------------------------
package popcnt_pkg;

    localparam int CHUNK_W     = 6;
    localparam int CHUNK_CNT_W = 3;

    function automatic int calc_nchunk(input int vec_width);
        return (vec_width + CHUNK_W - 1) / CHUNK_W;
    endfunction

    // ceil(log2(nchunk)); 0 when a single chunk needs no reduction.
    function automatic int calc_depth(input int nchunk);
        int d;
        d = 0;
        while ((1 << d) < nchunk) d++;
        return d;
    endfunction

    // Level 0 holds the chunk counts. Every later level halves the node
    // count, rounding up, so an odd node passes straight through.
    function automatic int nodes_at(input int nchunk, input int lvl);
        return (nchunk + (1 << lvl) - 1) >> lvl;
    endfunction

    // Each level gains one bit and is capped at the final count width.
    // Level l sums at most 6*2^l ones, so the cap never drops a carry.
    function automatic int lvl_width(input int lvl, input int popcnt_w);
        if (lvl == 0) return CHUNK_CNT_W;
        return (CHUNK_CNT_W + lvl < popcnt_w) ? CHUNK_CNT_W + lvl : popcnt_w;
    endfunction

endpackage

// File: rtl/lut6_popcount.sv
// ---------------------------------------------------------------------------
// lut6_popcount
// Purely combinational count of the ones in a 6-bit chunk. The function has
// six inputs, so each result bit fits in a single 6-input LUT.
//   bits : 6-bit chunk
//   cnt  : number of ones in bits (0..6)
// ---------------------------------------------------------------------------
module lut6_popcount
    import popcnt_pkg::*;
(
    input  logic [CHUNK_W-1:0]     bits,
    output logic [CHUNK_CNT_W-1:0] cnt
);

    always_comb begin
        // NOTE: cnt gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
        cnt = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            // NOTE: blocking assignment here, because each iteration has to read the value that was just accumulated.
            cnt = cnt + CHUNK_CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/vec_popcount_pipe.sv
// ---------------------------------------------------------------------------
// vec_popcount_pipe
// Pipelined population count with a threshold compare. Stage 0 registers
// the per-chunk LUT counts. Each following stage registers one level of the
// adder tree. The last level also performs the compare against thresh and
// drives the outputs. Latency is 1 + DEPTH cycles.
// All stages advance together when the output slot is free or is being
// drained (adv). A tag and a threshold shadow travel with each stage.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake (in_vec, in_tag, thresh)
//   out_valid/out_ready : output handshake (out_cnt, out_tag, out_ge)
//   out_cnt             : number of ones in the accepted vector
//   out_tag             : tag of the same transaction
//   out_ge              : out_cnt >= thresh sampled at accept
// ---------------------------------------------------------------------------
module vec_popcount_pipe
    import popcnt_pkg::*;
#(
    parameter int VEC_WIDTH    = 64,
    parameter int TAG_WIDTH    = 8,
    parameter int POPCNT_WIDTH = $clog2(VEC_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [VEC_WIDTH-1:0]    in_vec,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    input  logic [POPCNT_WIDTH-1:0] thresh,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [POPCNT_WIDTH-1:0] out_cnt,
    output logic [TAG_WIDTH-1:0]    out_tag,
    output logic                    out_ge
);

    localparam int NCHUNK = calc_nchunk(VEC_WIDTH);
    localparam int DEPTH  = calc_depth(NCHUNK);
    localparam int NSTG   = DEPTH + 1;
    localparam int PAD_W  = NCHUNK * CHUNK_W;

    logic                    adv;
    logic [NSTG-1:0]         vld_q;
    logic [PAD_W-1:0]        vec_pad;
    logic [POPCNT_WIDTH-1:0] fin_cnt;

    assign adv       = out_ready || !out_valid;
    // rst_n is included so that in_ready stays low while reset is held. Without
    // it, the empty pipe would report ready during reset.
    assign in_ready  = adv && rst_n;
    assign out_valid = vld_q[DEPTH];
    assign vec_pad   = PAD_W'(in_vec);   // top chunk zero-padded

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (adv) begin
            // NOTE: non-blocking, so every stage samples its predecessor's pre-edge value.
            vld_q <= (vld_q << 1) | NSTG'(in_valid);
        end
    end

    for (genvar l = 0; l <= DEPTH; l++) begin : gen_lvl
        localparam int NN = nodes_at(NCHUNK, l);
        localparam int LW = lvl_width(l, POPCNT_WIDTH);

        // Inputs to the register of this level (or to the output stage).
        logic [LW-1:0]           node_d [NN];
        logic [TAG_WIDTH-1:0]    tag_d;
        logic [POPCNT_WIDTH-1:0] thr_d;

        if (l == 0) begin : gen_src
            for (genvar c = 0; c < NCHUNK; c++) begin : gen_chunk
                lut6_popcount u_lut (
                    .bits (vec_pad[c*CHUNK_W +: CHUNK_W]),
                    .cnt  (node_d[c])
                );
            end
            assign tag_d = in_tag;
            assign thr_d = thresh;
        end else begin : gen_src
            localparam int PN = nodes_at(NCHUNK, l - 1);
            for (genvar i = 0; i < NN; i++) begin : gen_add
                if (2 * i + 1 < PN) begin : gen_pair
                    assign node_d[i] = LW'(gen_lvl[l-1].gen_reg.node_q[2*i])
                                     + LW'(gen_lvl[l-1].gen_reg.node_q[2*i+1]);
                end else begin : gen_pass
                    assign node_d[i] = LW'(gen_lvl[l-1].gen_reg.node_q[2*i]);
                end
            end
            assign tag_d = gen_lvl[l-1].gen_reg.tag_q;
            assign thr_d = gen_lvl[l-1].gen_reg.thr_q;
        end

        if (l < DEPTH) begin : gen_reg
            logic [LW-1:0]           node_q [NN];
            logic [TAG_WIDTH-1:0]    tag_q;
            logic [POPCNT_WIDTH-1:0] thr_q;

            // NOTE: the data, tag and thresh stage registers have no reset. The stage valid bit qualifies them, and leaving them unreset keeps the reset net off the datapath.
            always_ff @(posedge clk) begin
                if (adv) begin
                    node_q <= node_d;
                    tag_q  <= tag_d;
                    thr_q  <= thr_d;
                end
            end
        end
    end

    // Final tree level: the last add and the threshold compare share this cycle.
    assign fin_cnt = POPCNT_WIDTH'(gen_lvl[DEPTH].node_d[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
            out_tag <= '0;
            out_ge  <= 1'b0;
        end else if (adv) begin
            out_cnt <= fin_cnt;
            out_tag <= gen_lvl[DEPTH].tag_d;
            out_ge  <= (fin_cnt >= gen_lvl[DEPTH].thr_d);
        end
    end

endmodule

// File: tb/tb_vec_popcount_pipe.sv
// ---------------------------------------------------------------------------
// tb_vec_popcount_pipe
// Scoreboard bench. A 64-bit instance carries the main traffic. A 7-bit
// instance and a 6-bit instance cover the zero-padded chunk case and the
// no-tree (DEPTH=0) case.
// ---------------------------------------------------------------------------
module tb_vec_popcount_pipe;

    localparam int VW  = 64;
    localparam int TW  = 8;
    localparam int PW  = 7;   // $clog2(65)
    localparam int LAT = 5;   // 11 chunks -> 4 tree levels -> 1 + 4

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, out_valid, out_ready, out_ge;
    logic [VW-1:0] in_vec;
    logic [TW-1:0] in_tag, out_tag;
    logic [PW-1:0] thresh, out_cnt;

    logic          v7_in_valid, v7_in_ready, v7_out_valid, v7_out_ge;
    logic [6:0]    v7_in_vec;
    logic [TW-1:0] v7_in_tag, v7_out_tag;
    logic [2:0]    v7_thresh, v7_out_cnt;

    logic          v6_in_valid, v6_in_ready, v6_out_valid, v6_out_ge;
    logic [5:0]    v6_in_vec;
    logic [TW-1:0] v6_in_tag, v6_out_tag;
    logic [2:0]    v6_thresh, v6_out_cnt;

    always #5 clk = ~clk;

    vec_popcount_pipe #(.VEC_WIDTH(VW), .TAG_WIDTH(TW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .in_tag(in_tag), .thresh(thresh), .out_valid(out_valid),
        .out_ready(out_ready), .out_cnt(out_cnt), .out_tag(out_tag), .out_ge(out_ge)
    );

    vec_popcount_pipe #(.VEC_WIDTH(7), .TAG_WIDTH(TW)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(v7_in_valid), .in_ready(v7_in_ready),
        .in_vec(v7_in_vec), .in_tag(v7_in_tag), .thresh(v7_thresh), .out_valid(v7_out_valid),
        .out_ready(1'b1), .out_cnt(v7_out_cnt), .out_tag(v7_out_tag), .out_ge(v7_out_ge)
    );

    vec_popcount_pipe #(.VEC_WIDTH(6), .TAG_WIDTH(TW)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(v6_in_valid), .in_ready(v6_in_ready),
        .in_vec(v6_in_vec), .in_tag(v6_in_tag), .thresh(v6_thresh), .out_valid(v6_out_valid),
        .out_ready(1'b1), .out_cnt(v6_out_cnt), .out_tag(v6_out_tag), .out_ge(v6_out_ge)
    );

    typedef struct {
        logic [PW-1:0] cnt;
        logic [TW-1:0] tag;
        logic          ge;
        int unsigned   acc_cyc;
        bit            chk_lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_acc   = 0;
    int unsigned cyc     = 0;
    int          rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low
    bit          lat_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Called just after a rising edge. It holds the transaction until it is
    // accepted (bounded wait), pushes the expected result, and returns just
    // after the accepting edge.
    task automatic send(input logic [VW-1:0] v, input logic [TW-1:0] t,
                        input logic [PW-1:0] th, input int exp_cnt);
        exp_t e;
        int   waited;
        waited   = 0;
        in_valid = 1'b1;
        in_vec   = v;
        in_tag   = t;
        thresh   = th;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
        end else begin
            e.cnt     = PW'(exp_cnt);
            e.tag     = t;
            e.ge      = (exp_cnt >= int'(th));
            e.acc_cyc = cyc;
            e.chk_lat = lat_mode;
            sb.push_back(e);
            n_acc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output ready driver.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: retire-side checks, plus output stability while stalled.
    logic [PW-1:0] snap_cnt;
    logic [TW-1:0] snap_tag;
    logic          snap_ge;
    bit            snap_vld = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            snap_vld = 0;
        end else begin
            if (snap_vld) begin
                check("stall_valid", out_valid, 1);
                check("stall_cnt", out_cnt, snap_cnt);
                check("stall_tag", out_tag, snap_tag);
                check("stall_ge", out_ge, snap_ge);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", out_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_cnt", out_cnt, mon_e.cnt);
                    check("out_tag", out_tag, mon_e.tag);
                    check("out_ge", out_ge, mon_e.ge);
                    if (mon_e.chk_lat) check("latency", cyc - mon_e.acc_cyc, LAT);
                end
            end
            snap_vld = out_valid && !out_ready;
            snap_cnt = out_cnt;
            snap_tag = out_tag;
            snap_ge  = out_ge;
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] rv;
        int            lat6, lat7;
        int unsigned   c0;

        in_valid = 0; in_vec = '0; in_tag = '0; thresh = '0;
        v7_in_valid = 0; v7_in_vec = '0; v7_in_tag = '0; v7_thresh = '0;
        v6_in_valid = 0; v6_in_vec = '0; v6_in_tag = '0; v6_thresh = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_cnt", out_cnt, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_ge", out_ge, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_v7_valid", v7_out_valid, 0);
        check("rst_v6_valid", v6_out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        // All ones against the top threshold, with the latency checked
        lat_mode = 1;
        send('1, 8'hA5, 7'd64, 64);
        wait_drain();

        // Back-to-back with tags 1..4 and threshold 2
        send(64'h0, 8'd1, 7'd2, 0);
        send(64'h1, 8'd2, 7'd2, 1);
        send(64'h8000_0000_0000_0001, 8'd3, 7'd2, 2);
        send(64'hFFFF_FFFF, 8'd4, 7'd2, 32);
        wait_drain();

        // Threshold edges around the count
        send(64'h5555_5555_5555_5555, 8'h21, 7'd33, 32);
        send(64'h00FF_00FF_00FF_00FF, 8'h22, 7'd32, 32);
        send(64'h8000_0000_0000_0000, 8'h23, 7'd0, 1);
        send('1, 8'h24, 7'd127, 64);
        send(64'h0, 8'h25, 7'd0, 0);
        wait_drain();
        lat_mode = 0;

        // Stall: out_ready low for 10 cycles while 8 transactions are offered
        rdy_mode = 2;
        @(posedge clk); #2;
        n_acc = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send((64'h1 << (i + 1)) - 64'h1, 8'h10 + 8'(i), 7'd4, i + 1);
                end
            end
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready_low", in_ready, 0);
                check("stall_accepted", n_acc, 5);
                rdy_mode = 0;
            end
        join
        wait_drain();

        // Reset with 3 in flight
        send(64'hF, 8'h31, 7'd1, 4);
        send(64'hFF, 8'h32, 7'd1, 8);
        send(64'hFFF, 8'h33, 7'd1, 12);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_idle", out_valid, 0);
        @(posedge clk); #1;
        send(64'h0000_00FF_0000_0F0F, 8'h77, 7'd12, 16);
        wait_drain();

        // Narrow instances: padding at width 7, single stage at width 6
        v7_in_vec = 7'h7F; v7_in_tag = 8'h07; v7_thresh = 3'd7; v7_in_valid = 1'b1;
        v6_in_vec = 6'h3F; v6_in_tag = 8'h06; v6_thresh = 3'd6; v6_in_valid = 1'b1;
        @(negedge clk);
        check("v7_in_ready", v7_in_ready, 1);
        check("v6_in_ready", v6_in_ready, 1);
        c0 = cyc;
        @(posedge clk); #1;
        v7_in_valid = 1'b0;
        v6_in_valid = 1'b0;
        lat6 = -1;
        lat7 = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (v6_out_valid && lat6 < 0) begin
                lat6 = int'(cyc - c0);
                check("v6_cnt", v6_out_cnt, 6);
                check("v6_tag", v6_out_tag, 8'h06);
                check("v6_ge", v6_out_ge, 1);
            end
            if (v7_out_valid && lat7 < 0) begin
                lat7 = int'(cyc - c0);
                check("v7_cnt", v7_out_cnt, 7);
                check("v7_tag", v7_out_tag, 8'h07);
                check("v7_ge", v7_out_ge, 1);
            end
        end
        check("v6_latency", lat6, 1);
        check("v7_latency", lat7, 2);
        @(posedge clk); #1;

        // Random vectors with random backpressure
        rdy_mode = 1;
        for (int n = 0; n < 10000; n++) begin
            rv = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rv = '0;
            if ($urandom_range(0, 7) == 0) rv = '1;
            send(rv, 8'($urandom), 7'($urandom_range(0, 64)), $countones(rv));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rdy_mode = 0;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
